// File: rtl/sine_addr_gen_if.sv
// rtl/sine_addr_gen_if.sv - control and ROM-address bundle for the sine phase-accumulator address generator
interface sine_addr_gen_if #(
  parameter int ADD_WIDTH = 8,
  parameter int ACC_WIDTH = 16
);
  // control from the sequencer side
  logic                 clr;
  logic                 en;
  logic                 start;
  logic [ACC_WIDTH-1:0] incr;
  logic [ADD_WIDTH-1:0] offset;

  // addresses and qualifiers toward the dual-port sine ROM
  logic [ADD_WIDTH-1:0] addr;
  logic [ADD_WIDTH-1:0] addr2;
  logic                 valid;
  logic                 dvalid;
  logic                 wrap;

  // master drives the controls and consumes the addresses
  modport master (
    output clr, en, start, incr, offset,
    input  addr, addr2, valid, dvalid, wrap
  );

  // slave is the address generator itself
  modport slave (
    input  clr, en, start, incr, offset,
    output addr, addr2, valid, dvalid, wrap
  );
endinterface

// File: rtl/sine_addr_gen.sv
// rtl/sine_addr_gen.sv - phase-accumulator address generator for both ports of the sine ROM
module sine_addr_gen #(
  parameter int ADD_WIDTH = 8,
  parameter int ACC_WIDTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  sine_addr_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    ONESHOT = 2'd2
  } state_t;

  state_t               state;
  state_t               state_d;

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [ACC_WIDTH-1:0] incr_q;
  logic [ACC_WIDTH-1:0] incr_q_d;
  logic [ACC_WIDTH:0]   sum;
  logic                 carry;
  logic                 wrap_d;

  logic [ADD_WIDTH-1:0] addr2_q;
  logic [ADD_WIDTH-1:0] addr2_d;
  logic                 valid_q;
  logic                 dvalid_q;
  logic                 wrap_q;

  // one extra bit on the adder exposes the period boundary (carry-out)
  assign sum   = {1'b0, acc} + {1'b0, incr_q};
  assign carry = sum[ACC_WIDTH];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // next state, next phase, tuning-word shadow and wrap pulse
  always_comb begin
    state_d  = state;
    acc_d    = acc;
    incr_q_d = incr_q;
    wrap_d   = 1'b0;

    if (bus.clr) begin
      state_d = IDLE;
      acc_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            // resume from the held phase; first advance happens next edge
            state_d  = RUN;
            incr_q_d = bus.incr;
          end else if (bus.start && (bus.incr != '0)) begin
            // one-shot always begins at phase zero
            state_d  = ONESHOT;
            incr_q_d = bus.incr;
            acc_d    = '0;
          end
        end

        RUN: begin
          if (!bus.en) begin
            // pause: acc keeps its current value
            state_d = IDLE;
          end else begin
            acc_d = sum[ACC_WIDTH-1:0];
            if (carry) begin
              // new tuning word only at the period boundary
              wrap_d   = 1'b1;
              incr_q_d = bus.incr;
            end
          end
        end

        ONESHOT: begin
          acc_d = sum[ACC_WIDTH-1:0];
          if (bus.en) begin
            // promoted to continuous running without losing phase
            state_d = RUN;
            if (carry) begin
              wrap_d   = 1'b1;
              incr_q_d = bus.incr;
            end
          end else if (carry) begin
            // end of the single period: park exactly at zero
            acc_d   = '0;
            wrap_d  = 1'b1;
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // second port follows the next phase so both addresses land together
  assign addr2_d = acc_d[ACC_WIDTH-1 -: ADD_WIDTH] + bus.offset;

  // datapath registers: phase, tuning shadow, second address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      incr_q  <= '0;
      addr2_q <= '0;
    end else begin
      acc     <= acc_d;
      incr_q  <= incr_q_d;
      addr2_q <= addr2_d;
    end
  end

  // qualifiers: valid tracks the active sweep, dvalid follows the ROM's read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      dvalid_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      valid_q  <= (state_d != IDLE);
      dvalid_q <= valid_q;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.addr   = acc[ACC_WIDTH-1 -: ADD_WIDTH];
  assign bus.addr2  = addr2_q;
  assign bus.valid  = valid_q;
  assign bus.dvalid = dvalid_q;
  assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_sine_addr_gen.sv
// tb/tb_sine_addr_gen.sv - scoreboard bench for sine_addr_gen
module tb_sine_addr_gen;
  localparam int AW = 8;
  localparam int CW = 16;

  logic clk;
  logic rst_n;

  sine_addr_gen_if #(.ADD_WIDTH(AW), .ACC_WIDTH(CW)) bus ();

  sine_addr_gen #(.ADD_WIDTH(AW), .ACC_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] addr2;
    logic       valid;
    logic       dvalid;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // reference state
  int unsigned m_acc = 0;
  int unsigned m_iq  = 0;
  int          m_st  = 0;   // 0 idle, 1 run, 2 one-shot
  bit          m_valid  = 0;
  bit          m_dvalid = 0;
  bit          m_wrap   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // predict the outputs after the coming edge and queue them
  task automatic model_step();
    int unsigned s;
    bit          cy;
    int          nst;
    exp_t        e;
    nst    = m_st;
    m_wrap = 0;
    if (bus.clr) begin
      m_acc = 0;
      nst   = 0;
    end else if (m_st == 0) begin
      if (bus.en) begin
        nst  = 1;
        m_iq = 32'(bus.incr);
      end else if (bus.start && bus.incr != 0) begin
        nst   = 2;
        m_iq  = 32'(bus.incr);
        m_acc = 0;
      end
    end else if (m_st == 1 && !bus.en) begin
      nst = 0;
    end else begin
      s     = m_acc + m_iq;
      cy    = (s >= 65536);
      m_acc = s % 65536;
      if (m_st == 1 || bus.en) begin
        nst = 1;
        if (cy) begin
          m_wrap = 1;
          m_iq   = 32'(bus.incr);
        end
      end else if (cy) begin
        m_acc  = 0;
        m_wrap = 1;
        nst    = 0;
      end
    end
    m_dvalid = m_valid;
    m_valid  = (nst != 0);
    m_st     = nst;
    e.addr   = 8'(m_acc / 256);
    e.addr2  = 8'(((m_acc / 256) + 32'(bus.offset)) % 256);
    e.valid  = m_valid;
    e.dvalid = m_dvalid;
    e.wrap   = m_wrap;
    exp_q.push_back(e);
  endtask

  // one clock: queue the prediction, let the edge happen, pop and compare
  task automatic step();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("addr",   32'(bus.addr),   32'(e.addr));
      check("addr2",  32'(bus.addr2),  32'(e.addr2));
      check("valid",  32'(bus.valid),  32'(e.valid));
      check("dvalid", 32'(bus.dvalid), 32'(e.dvalid));
      check("wrap",   32'(bus.wrap),   32'(e.wrap));
    end
  endtask

  task automatic run_until_addr(input int target, input int bound);
    int n;
    n = 0;
    while (32'(bus.addr) != target && n < bound) begin
      step();
      n++;
    end
    if (n >= bound) check("timeout_addr", 32'(bus.addr), 32'(target));
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_valid;
    int n_dvalid;
    int n_wrap;
    int seen;

    rst_n      = 1'b0;
    bus.clr    = 1'b0;
    bus.en     = 1'b0;
    bus.start  = 1'b0;
    bus.incr   = '0;
    bus.offset = '0;
    #12;
    check("rst_addr",   32'(bus.addr),   32'd0);
    check("rst_addr2",  32'(bus.addr2),  32'd0);
    check("rst_valid",  32'(bus.valid),  32'd0);
    check("rst_dvalid", 32'(bus.dvalid), 32'd0);
    check("rst_wrap",   32'(bus.wrap),   32'd0);
    rst_n = 1'b1;
    step();

    // continuous sweep with offset
    bus.offset = 8'h40;
    bus.incr   = 16'h0100;
    bus.en     = 1'b1;
    n_wrap = 0;
    for (int i = 0; i <= 256; i++) begin
      step();
      check("cont_addr",  32'(bus.addr),  32'(i % 256));
      check("cont_addr2", 32'(bus.addr2), 32'((i + 'h40) % 256));
      if (bus.wrap) begin
        n_wrap++;
        check("cont_wrap_at0", 32'(bus.addr), 32'd0);
      end
    end
    check("cont_wrap_count", 32'(n_wrap), 32'd1);
    bus.en = 1'b0;
    step();
    check("cont_stop_valid", 32'(bus.valid), 32'd0);

    // one-shot
    do_clr();
    bus.start = 1'b1;
    n_valid = 0; n_dvalid = 0; n_wrap = 0;
    for (int i = 0; i < 260; i++) begin
      step();
      bus.start = 1'b0;
      if (bus.valid) begin
        check("os_addr", 32'(bus.addr), 32'(n_valid));
        n_valid++;
      end
      if (bus.dvalid) n_dvalid++;
      if (bus.wrap) begin
        n_wrap++;
        check("os_wrap_addr",  32'(bus.addr),  32'd0);
        check("os_wrap_valid", 32'(bus.valid), 32'd0);
      end
    end
    check("os_valid_count",  32'(n_valid),  32'd256);
    check("os_dvalid_count", 32'(n_dvalid), 32'd256);
    check("os_wrap_count",   32'(n_wrap),   32'd1);
    check("os_end_addr",     32'(bus.addr), 32'd0);

    // fractional rate and deferred rate change
    do_clr();
    bus.incr = 16'h0180;
    bus.en   = 1'b1;
    step(); check("frac0", 32'(bus.addr), 32'd0);
    step(); check("frac1", 32'(bus.addr), 32'd1);
    step(); check("frac2", 32'(bus.addr), 32'd3);
    step(); check("frac3", 32'(bus.addr), 32'd4);
    step(); check("frac4", 32'(bus.addr), 32'd6);
    run_until_addr('h10, 50);
    bus.incr = 16'h0200;
    step(); check("frac_keep", 32'(bus.addr), 32'h12);
    seen = 0;
    for (int i = 0; i < 300 && seen == 0; i++) begin
      step();
      if (bus.wrap) seen = 1;
    end
    check("frac_wrap_seen", 32'(seen), 32'd1);
    check("frac_wrap_addr", 32'(bus.addr), 32'd0);
    step(); check("frac_new1", 32'(bus.addr), 32'd2);
    step(); check("frac_new2", 32'(bus.addr), 32'd4);

    // pause and resume
    do_clr();
    bus.incr = 16'h0100;
    step();
    run_until_addr('h30, 100);
    bus.en = 1'b0;
    step();
    check("pause_addr",  32'(bus.addr),  32'h30);
    check("pause_valid", 32'(bus.valid), 32'd0);
    step();
    check("pause_hold", 32'(bus.addr), 32'h30);
    bus.en = 1'b1;
    step();
    check("resume_addr",  32'(bus.addr),  32'h30);
    check("resume_valid", 32'(bus.valid), 32'd1);
    step();
    check("resume_next", 32'(bus.addr), 32'h31);

    // corner requests
    bus.en = 1'b0;
    do_clr();
    bus.incr  = '0;
    bus.start = 1'b1;
    step(); check("start_incr0_valid", 32'(bus.valid), 32'd0);
    step(); check("start_incr0_valid2", 32'(bus.valid), 32'd0);
    bus.start = 1'b0;
    bus.incr  = 16'h0100;
    bus.en    = 1'b1;
    run_until_addr(5, 20);
    bus.en = 1'b0;
    step();
    bus.en    = 1'b1;
    bus.start = 1'b1;
    step();
    check("en_start_addr",  32'(bus.addr),  32'd5);
    check("en_start_valid", 32'(bus.valid), 32'd1);
    bus.start = 1'b0;
    step();
    check("en_start_next", 32'(bus.addr), 32'd6);
    bus.offset = 8'h22;
    bus.clr    = 1'b1;
    step();
    check("clr_addr",  32'(bus.addr),  32'd0);
    check("clr_addr2", 32'(bus.addr2), 32'h22);
    check("clr_valid", 32'(bus.valid), 32'd0);
    bus.clr = 1'b0;
    step();
    check("clr_rerun_valid", 32'(bus.valid), 32'd1);
    step();
    // zero tuning word while running freezes the phase
    bus.en = 1'b0;
    step();
    bus.incr = '0;
    bus.en   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("zero_incr_addr", 32'(bus.addr), 32'd1);
    end

    // asynchronous reset in the middle of a one-shot
    bus.en = 1'b0;
    do_clr();
    bus.incr  = 16'h0100;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    run_until_addr('h80, 200);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_addr",   32'(bus.addr),   32'd0);
    check("arst_addr2",  32'(bus.addr2),  32'd0);
    check("arst_valid",  32'(bus.valid),  32'd0);
    check("arst_dvalid", 32'(bus.dvalid), 32'd0);
    check("arst_wrap",   32'(bus.wrap),   32'd0);
    m_acc = 0; m_iq = 0; m_st = 0; m_valid = 0; m_dvalid = 0; m_wrap = 0;
    @(posedge clk);
    #1;
    check("arst_held_addr", 32'(bus.addr), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_addr",  32'(bus.addr),  32'd0);
      check("post_rst_valid", 32'(bus.valid), 32'd0);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("post_rst_start_valid", 32'(bus.valid), 32'd1);
    step();
    check("post_rst_start_addr", 32'(bus.addr), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sine_addr_gen.md
# sine_addr_gen

Phase-accumulator address generator that drives both read ports of the dual-port sine ROM. It steps an ACC_WIDTH-bit phase accumulator by a frequency tuning word and presents the top ADD_WIDTH bits as `addr`. It also presents a phase-offset copy as `addr2`. It supports continuous and single-period (one-shot) sweeps, with `valid` qualifiers aligned to both the address and the ROM's one-cycle registered data.

## Interface
- ADD_WIDTH, 8, ROM address width; must match the ROM.
- ACC_WIDTH, 16, phase accumulator width; must be ≥ ADD_WIDTH.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of accumulator and state.
- en  in  1  continuous run enable (level).
- start  in  1  one-shot request (pulse, sampled on rising edge).
- incr  in  ACC_WIDTH  frequency tuning word.
- offset  in  ADD_WIDTH  phase offset for the second port.
- addr  out  ADD_WIDTH  ROM port-1 address; equals acc[ACC_WIDTH-1 -: ADD_WIDTH].
- addr2  out  ADD_WIDTH  ROM port-2 address; (addr + offset) mod 2^ADD_WIDTH.
- valid  out  1  addr/addr2 belong to an active sweep.
- dvalid  out  1  valid delayed one cycle; qualifies ROM dout/dout2.
- wrap  out  1  one-cycle pulse on accumulator carry-out.

## Operation
- Registers:
  - acc (ACC_WIDTH)
  - incr_q (ACC_WIDTH, shadow tuning word)
  - addr2 (registered)
  - state (IDLE, RUN, ONESHOT)
  - valid, dvalid, wrap
- All outputs are registered; addr is a slice of the acc register.
- Priority at each edge: rst_n > clr > en > start.
- Reset (async): acc=0, incr_q=0, addr=0, addr2=0, state=IDLE, valid=0, dvalid=0, wrap=0.
- clr: acc←0, addr2←offset, state←IDLE, wrap←0. The dvalid pipeline still shifts.
- IDLE:
  - en=1 → RUN, incr_q←incr; acc unchanged (resume from held phase).
  - en=0, start=1, incr≠0 → ONESHOT, incr_q←incr, acc←0.
  - start with incr=0 is ignored.
  - acc holds while in IDLE.
- RUN:
  - acc←acc+incr_q mod 2^ACC_WIDTH every cycle.
  - On carry-out: incr_q←incr, so frequency changes only at period boundaries.
  - en=0 → IDLE; the acc value from that edge is held (pause, no clear).
  - start is ignored.
- ONESHOT:
  - Advances as in RUN.
  - On carry-out: acc←0 (forced), state→IDLE.
  - en=1 → RUN without clearing acc.
  - start is ignored.
- addr2 is updated every edge from the next acc top bits + current offset. An offset change takes effect on the next edge.
- valid←(next state ≠ IDLE); dvalid←valid.
- wrap←1 on the edge where the carry-out occurs (RUN or ONESHOT), else 0.
- incr_q=0 in RUN: acc frozen, no wrap, valid stays 1.

## Timing
- Edge k samples en=1 in IDLE. From k, valid=1 and addr shows the held acc. The first advance is at edge k+1.
- Edge k samples start in IDLE. From k, addr=0 and valid=1. Sweep length = ceil(2^ACC_WIDTH / incr_q) valid cycles. At the carry edge, addr=0, valid=0, wrap=1 for one cycle.
- dvalid trails valid by exactly one cycle, matching the ROM's registered read.
- Async reset mid-sweep: outputs go to reset values immediately. After release, nothing moves until en/start is sampled.
- Simultaneous en and start in IDLE: enter RUN, acc not cleared.
- clr together with en: clr wins. Enter RUN on the next edge if en is still high.
- wrap and an incr change on the same edge: the new incr is latched at that edge.

## Test plan
- Continuous, incr=0x0100, offset=0x40, en=1:
  - addr steps 0,1,2,…,255,0.
  - addr2 steps 0x40,0x41,…, wrapping 0xFF→0x00 when addr=0xC0.
  - wrap pulses exactly once, when addr returns to 0.
- One-shot, incr=0x0100, start pulse:
  - Exactly 256 valid cycles, addr 0..255.
  - Then addr=0, valid=0, and one wrap pulse.
  - dvalid high for 256 cycles, offset by one.
- Fractional/rate change:
  - incr=0x0180 gives addr 0,1,3,4,6,…
  - Changing incr to 0x0200 at addr=0x10 keeps the 0x0180 stepping until the next wrap, then steps by 2.
- Pause/resume: drop en at addr=0x30.
  - addr holds 0x30 and valid=0 on the next cycle.
  - Re-raise en: addr stays 0x30 for one valid cycle, then 0x31 (incr=0x0100).
- Corner requests:
  - start with incr=0 leaves state IDLE and valid=0.
  - start+en together gives RUN with acc not cleared.
  - clr during RUN gives addr=0, addr2=offset, valid=0.
- Reset mid-one-shot at addr=0x80: all outputs 0 without waiting for a clock edge. No activity after release until the next start.
